// File: rtl/scalar_mult_ctrl_if.sv
// Handshake and operand bundle between the signature engine, the scalar-multiplication
// sequencer and the external point_double / point_add units.
interface scalar_mult_ctrl_if #(
    parameter int unsigned DATA_WIDTH   = 448,
    parameter int unsigned SCALAR_WIDTH = 448
);
    logic                    start;
    logic [SCALAR_WIDTH-1:0] scalar;
    logic [DATA_WIDTH-1:0]   px, py, pz;
    logic                    busy;
    logic                    done;
    logic [DATA_WIDTH-1:0]   rx, ry, rz;

    logic                    dbl_start;
    logic [DATA_WIDTH-1:0]   dbl_x1, dbl_y1, dbl_z1;
    logic [DATA_WIDTH-1:0]   dbl_x3, dbl_y3, dbl_z3;
    logic                    dbl_done;

    logic                    add_start;
    logic [DATA_WIDTH-1:0]   add_x1, add_y1, add_z1;
    logic [DATA_WIDTH-1:0]   add_x2, add_y2, add_z2;
    logic [DATA_WIDTH-1:0]   add_x3, add_y3, add_z3;
    logic                    add_done;

    // Requester / point-unit side.
    modport master (
        output start, scalar, px, py, pz,
        output dbl_x3, dbl_y3, dbl_z3, dbl_done,
        output add_x3, add_y3, add_z3, add_done,
        input  busy, done, rx, ry, rz,
        input  dbl_start, dbl_x1, dbl_y1, dbl_z1,
        input  add_start, add_x1, add_y1, add_z1, add_x2, add_y2, add_z2
    );

    // Sequencer side.
    modport slave (
        input  start, scalar, px, py, pz,
        input  dbl_x3, dbl_y3, dbl_z3, dbl_done,
        input  add_x3, add_y3, add_z3, add_done,
        output busy, done, rx, ry, rz,
        output dbl_start, dbl_x1, dbl_y1, dbl_z1,
        output add_start, add_x1, add_y1, add_z1, add_x2, add_y2, add_z2
    );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// MSB-first double-and-add sequencer for Ed448 R = k*P over external double/add units.
// Define SCALAR_MULT_CONST_TIME_EN to issue an add for every bit (k-independent timing).
module scalar_mult_ctrl #(
    parameter int unsigned           DATA_WIDTH   = 448,
    parameter int unsigned           SCALAR_WIDTH = 448,
    parameter logic [DATA_WIDTH-1:0] ONE_MONT     = (DATA_WIDTH'(1) << 224) | DATA_WIDTH'(1)
) (
    input logic               clk,
    input logic               rst,
    scalar_mult_ctrl_if.slave bus
);
    localparam int unsigned IdxW = (SCALAR_WIDTH > 1) ? $clog2(SCALAR_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StDblIssue,
        StDblWait,
        StAddIssue,
        StAddWait,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [SCALAR_WIDTH-1:0] k_q, k_d;
    logic [DATA_WIDTH-1:0]   px_q, py_q, pz_q, px_d, py_d, pz_d;
    logic [DATA_WIDTH-1:0]   rx_q, ry_q, rz_q, rx_d, ry_d, rz_d;
    logic                    last_bit;
    logic                    bit_set;

    assign last_bit = (idx_q == '0);
    assign bit_set  = k_q[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            k_q     <= '0;
            px_q    <= '0;
            py_q    <= '0;
            pz_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            rz_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pz_q    <= pz_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            rz_q    <= rz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        px_d    = px_q;
        py_d    = py_q;
        pz_d    = pz_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        rz_d    = rz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    k_d     = bus.scalar;
                    px_d    = bus.px;
                    py_d    = bus.py;
                    pz_d    = bus.pz;
                    rx_d    = '0;
                    ry_d    = ONE_MONT;
                    rz_d    = ONE_MONT;
                    idx_d   = IdxW'(SCALAR_WIDTH - 1);
                    state_d = StDblIssue;
                end
            end
            StDblIssue: state_d = StDblWait;
            StDblWait: begin
                if (bus.dbl_done) begin
                    rx_d = bus.dbl_x3;
                    ry_d = bus.dbl_y3;
                    rz_d = bus.dbl_z3;
`ifdef SCALAR_MULT_CONST_TIME_EN
                    state_d = StAddIssue;
`else
                    if (bit_set) begin
                        state_d = StAddIssue;
                    end else if (last_bit) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q - IdxW'(1);
                        state_d = StDblIssue;
                    end
`endif
                end
            end
            StAddIssue: state_d = StAddWait;
            StAddWait: begin
                if (bus.add_done) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
                    // Dummy add for a zero bit: result discarded, timing unchanged.
                    if (bit_set) begin
                        rx_d = bus.add_x3;
                        ry_d = bus.add_y3;
                        rz_d = bus.add_z3;
                    end
`else
                    rx_d = bus.add_x3;
                    ry_d = bus.add_y3;
                    rz_d = bus.add_z3;
`endif
                    if (last_bit) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q - IdxW'(1);
                        state_d = StDblIssue;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.dbl_start = (state_q == StDblIssue);
    assign bus.add_start = (state_q == StAddIssue);

    assign bus.rx = rx_q;
    assign bus.ry = ry_q;
    assign bus.rz = rz_q;

    assign bus.dbl_x1 = rx_q;
    assign bus.dbl_y1 = ry_q;
    assign bus.dbl_z1 = rz_q;

    assign bus.add_x1 = rx_q;
    assign bus.add_y1 = ry_q;
    assign bus.add_z1 = rz_q;
    assign bus.add_x2 = px_q;
    assign bus.add_y2 = py_q;
    assign bus.add_z2 = pz_q;
endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl with stub point units (dbl: X*2, add: X1+X2, Y1+Y2, Z2).
// Honours SCALAR_MULT_CONST_TIME_EN for the expected add count and done cycle.
module tb_scalar_mult_ctrl;
    localparam int unsigned DW = 448;
    localparam int unsigned SW = 8;
    localparam logic [DW-1:0] ONE_MONT = (448'd1 << 224) | 448'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scalar_mult_ctrl_if #(.DATA_WIDTH(DW), .SCALAR_WIDTH(SW)) bus ();

    scalar_mult_ctrl #(
        .DATA_WIDTH  (DW),
        .SCALAR_WIDTH(SW),
        .ONE_MONT    (ONE_MONT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    int          ld     = 3;
    int          la     = 5;
    int          dbl_pulses = 0;
    int          add_pulses = 0;
    int          dbl_left   = 0;
    int          add_left   = 0;
    logic [DW-1:0] d_x, d_y, d_z, a_x1, a_y1, a_z1, a_x2, a_y2, a_z2;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Algebraic reference for the stub units: x = k*px, y = 1 + popcount(k)*py, z = pz if k != 0.
    function automatic void ref_model(input logic [SW-1:0] k, input logic [DW-1:0] x, y, z,
                                      output logic [DW-1:0] ex, ey, ez, output int nadd);
        int pc;
        pc = $countones(k);
        ex = x * DW'(k);
        ey = ONE_MONT + y * DW'(pc);
        ez = (k == '0) ? ONE_MONT : z;
`ifdef SCALAR_MULT_CONST_TIME_EN
        nadd = SW;
`else
        nadd = pc;
`endif
    endfunction

    // Doubler stub.
    initial begin
        bus.dbl_done = 1'b0;
        bus.dbl_x3 = '0; bus.dbl_y3 = '0; bus.dbl_z3 = '0;
        forever begin
            @(posedge clk); #1;
            bus.dbl_done = 1'b0;
            if (dbl_left > 0) begin
                dbl_left--;
                if (dbl_left == 0) begin
                    bus.dbl_x3 = d_x << 1;
                    bus.dbl_y3 = d_y;
                    bus.dbl_z3 = d_z;
                    bus.dbl_done = 1'b1;
                    if (bus.busy) begin
                        checks++;
                        if (bus.dbl_x1 !== d_x || bus.dbl_y1 !== d_y || bus.dbl_z1 !== d_z) begin
                            errors++;
                            $display("FAIL dbl_operand_stable: got %0h expected %0h",
                                     bus.dbl_x1, d_x);
                        end
                    end
                end
            end
            if (bus.dbl_start) begin
                d_x = bus.dbl_x1; d_y = bus.dbl_y1; d_z = bus.dbl_z1;
                dbl_left = ld;
                dbl_pulses++;
            end
        end
    end

    // Adder stub.
    initial begin
        bus.add_done = 1'b0;
        bus.add_x3 = '0; bus.add_y3 = '0; bus.add_z3 = '0;
        forever begin
            @(posedge clk); #1;
            bus.add_done = 1'b0;
            if (add_left > 0) begin
                add_left--;
                if (add_left == 0) begin
                    bus.add_x3 = a_x1 + a_x2;
                    bus.add_y3 = a_y1 + a_y2;
                    bus.add_z3 = a_z2;
                    bus.add_done = 1'b1;
                    if (bus.busy) begin
                        checks++;
                        if (bus.add_x1 !== a_x1 || bus.add_x2 !== a_x2 ||
                            bus.add_y2 !== a_y2 || bus.add_z2 !== a_z2) begin
                            errors++;
                            $display("FAIL add_operand_stable: got %0h expected %0h",
                                     bus.add_x2, a_x2);
                        end
                    end
                end
            end
            if (bus.add_start) begin
                a_x1 = bus.add_x1; a_y1 = bus.add_y1; a_z1 = bus.add_z1;
                a_x2 = bus.add_x2; a_y2 = bus.add_y2; a_z2 = bus.add_z2;
                add_left = la;
                add_pulses++;
            end
        end
    end

    // Drives one start pulse from Idle; inputs are scrambled right after acceptance.
    task automatic do_start(input logic [SW-1:0] k, input logic [DW-1:0] x, y, z,
                            output int unsigned c0);
        @(negedge clk);
        bus.scalar = k; bus.px = x; bus.py = y; bus.pz = z;
        bus.start = 1'b1;
        c0 = cyc;
        dbl_pulses = 0;
        add_pulses = 0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.scalar = SW'($urandom);
        bus.px = rand_wide(); bus.py = rand_wide(); bus.pz = rand_wide();
    endtask

    task automatic wait_done(input int budget, output bit seen, output int unsigned dcyc);
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < budget; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    function automatic int max_cycles();
        return SW * (ld + 1) + SW * (la + 1) + 20;
    endfunction

    task automatic test_reset();
        bus.start = 1'b0;
        bus.scalar = '0; bus.px = '0; bus.py = '0; bus.pz = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.dbl_start, bus.add_start} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.busy, bus.done, bus.dbl_start, bus.add_start});
        end
        checks++;
        if (bus.rx !== '0 || bus.ry !== '0 || bus.rz !== '0) begin
            errors++;
            $display("FAIL reset_acc: got %0h/%0h/%0h expected 0", bus.rx, bus.ry, bus.rz);
        end
        rst = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [SW-1:0] k,
                                 input logic [DW-1:0] x, y, z);
        int unsigned c0, dcyc;
        bit seen;
        logic [DW-1:0] ex, ey, ez;
        int nadd;
        ref_model(k, x, y, z, ex, ey, ez, nadd);
        do_start(k, x, y, z, c0);
        checks++;
        if (bus.busy !== 1'b1 || bus.dbl_start !== 1'b1) begin
            errors++;
            $display("FAIL %s first_dbl: got busy=%b dbl_start=%b expected 1 1",
                     name, bus.busy, bus.dbl_start);
        end
        wait_done(max_cycles(), seen, dcyc);
        checks++;
        if (!seen || dcyc - c0 != SW * (ld + 1) + nadd * (la + 1) + 1) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, seen ? dcyc - c0 : -1,
                     SW * (ld + 1) + nadd * (la + 1) + 1);
        end
        checks++;
        if (bus.rx !== ex || bus.ry !== ey || bus.rz !== ez) begin
            errors++;
            $display("FAIL %s result: got %0h/%0h/%0h expected %0h/%0h/%0h",
                     name, bus.rx, bus.ry, bus.rz, ex, ey, ez);
        end
        checks++;
        if (dbl_pulses != SW || add_pulses != nadd) begin
            errors++;
            $display("FAIL %s pulses: got %0d/%0d expected %0d/%0d",
                     name, dbl_pulses, add_pulses, SW, nadd);
        end
    endtask

    task automatic test_vector_a5();
        ld = 3; la = 5;
        run_and_check("k_a5", 8'hA5, 448'd3, rand_wide(), rand_wide());
        checks++;
        if (bus.rx !== 448'h1EF) begin
            errors++;
            $display("FAIL k_a5_rx: got %0h expected 1ef", bus.rx);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rx !== 448'h1EF) begin
            errors++;
            $display("FAIL k_a5_hold: got done=%b busy=%b rx=%0h expected 0 0 1ef",
                     bus.done, bus.busy, bus.rx);
        end
    endtask

    task automatic test_zero_scalar();
        ld = 3; la = 5;
        run_and_check("k_00", 8'h00, 448'd7, rand_wide(), rand_wide());
        checks++;
        if (bus.rx !== '0 || bus.ry !== ONE_MONT || bus.rz !== ONE_MONT) begin
            errors++;
            $display("FAIL k_00_neutral: got %0h/%0h/%0h expected neutral",
                     bus.rx, bus.ry, bus.rz);
        end
    endtask

    task automatic test_reset_mid_op();
        int unsigned c0, dcyc;
        bit seen;
        int stray;
        ld = 3; la = 5;
        do_start(8'hFF, 448'd9, 448'd1, 448'd2, c0);
        while (cyc != c0 + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.dbl_start, bus.add_start} !== 4'b0 ||
            bus.rx !== '0 || bus.ry !== '0 || bus.rz !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got ctrl=%b rx=%0h expected all 0",
                     {bus.busy, bus.done, bus.dbl_start, bus.add_start}, bus.rx);
        end
        rst = 1'b0;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rx !== '0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midreset_late_done: got %0d active cycles expected 0", stray);
        end
        run_and_check("after_reset", 8'h03, 448'd5, 448'd4, 448'd6);
        checks++;
        if (bus.rx !== 448'd15) begin
            errors++;
            $display("FAIL after_reset_rx: got %0h expected f", bus.rx);
        end
    endtask

    task automatic test_start_while_busy();
        int unsigned c0;
        int dones;
        logic [DW-1:0] x, ex, ey, ez, rx_at_done;
        int nadd;
        ld = 3; la = 5;
        x = rand_wide();
        ref_model(8'h81, x, 448'd11, 448'd12, ex, ey, ez, nadd);
        do_start(8'h81, x, 448'd11, 448'd12, c0);
        dones = 0;
        rx_at_done = '0;
        for (int i = 0; i < max_cycles() + 20; i++) begin
            if (cyc == c0 + 10) begin
                bus.scalar = 8'h7E; bus.px = rand_wide(); bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                dones++;
                rx_at_done = bus.rx;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL busy_start_dones: got %0d expected 1", dones);
        end
        checks++;
        if (rx_at_done !== ex) begin
            errors++;
            $display("FAIL busy_start_rx: got %0h expected %0h", rx_at_done, ex);
        end
    endtask

    // Back-to-back random operations with per-op random unit latencies.
    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            ld = $urandom_range(1, 4);
            la = $urandom_range(1, 4);
            run_and_check($sformatf("rand%0d", n), SW'($urandom), rand_wide(), rand_wide(),
                          rand_wide());
        end
        ld = 1; la = 1;
        run_and_check("k_ff", 8'hFF, rand_wide(), rand_wide(), rand_wide());
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_vector_a5();
        test_zero_scalar();
        test_reset_mid_op();
        test_start_while_busy();
        test_random();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
